sdram_report_uart: RTL and testbench

- Downstream consumer of the SDRAM test core's result reports; sits between that core and the board UART_TXD pin.
- Accepts a tagged 32-bit report word (error address, pass count, etc.) over a valid/ready handshake.
- Formats each word as an 11-character ASCII line and serialises it as 8N1 on txd.
- Runs on the system clock and uses the same frequency-parameter convention as the rest of the design.

---
 rtl/sdram_report_uart.sv | 91 +++++++++
 tb/tb_sdram_report_uart.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sdram_report_uart.sv
// sdram_report_uart: formats tagged 32-bit report words as 11-character ASCII hex lines and sends them as 8N1 UART
module sdram_report_uart #(
    parameter int sysclk_frequency = 1250,
    parameter int baud_rate = 115200
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_tag,
    input  logic [31:0] in_data,
    output logic        txd,
    output logic        busy,
    output logic [15:0] frames_sent
);
    localparam int RAW = (sysclk_frequency * 100000) / baud_rate;
    localparam int DIV = RAW < 2 ? 2 : RAW;
    localparam int CW = $clog2(DIV);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [39:0] hold;
    logic [3:0] idx, idx_n, nib;
    logic [2:0] bitn, bit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic last, load, done, txd_n;
    logic [7:0] hex, ch;
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign last = cnt == CW'(DIV - 1);
    // character under transmission, taken from the captured word only
    always_comb begin
        nib = 4'(hold[31:0] >> {4'd8 - idx, 2'b00});
        hex = nib < 4'd10 ? {4'h3, nib} : {4'h0, nib} + 8'h37;
        ch = idx == 4'd0 ? hold[39:32] : idx <= 4'd8 ? hex : idx == 4'd9 ? 8'h0D : 8'h0A;
    end
    // next-state logic; txd is precomputed so the pin comes straight from a flop
    always_comb begin
        state_n = state;
        idx_n = idx;
        bit_n = bitn;
        cnt_n = (state == IDLE || last) ? '0 : cnt + CW'(1);
        load = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                state_n = START;
                idx_n = 4'd0;
                load = 1'b1;
            end
            START: if (last) begin
                state_n = DATA;
                bit_n = 3'd0;
            end
            DATA: if (last) begin
                bit_n = bitn + 3'd1;
                if (bitn == 3'd7) state_n = STOP;
            end
            STOP: if (last) begin
                if (idx == 4'd10) begin
                    state_n = IDLE;
                    done = 1'b1;
                end else begin
                    idx_n = idx + 4'd1;
                    state_n = START;
                end
            end
            default: state_n = IDLE;
        endcase
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? ch[bit_n] : 1'b1;
    end
    // state, capture register, serial output and frame counter
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
            idx <= '0;
            bitn <= '0;
            cnt <= '0;
            hold <= '0;
            txd <= 1'b1;
            frames_sent <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            bitn <= bit_n;
            cnt <= cnt_n;
            txd <= txd_n;
            if (load) hold <= {in_tag, in_data};
            if (done) frames_sent <= frames_sent + 16'd1;
        end
    end
endmodule

// File: tb/tb_sdram_report_uart.sv
// tb_sdram_report_uart: randomized and directed checks of the report UART against a line-level reference
module tb_sdram_report_uart;
    localparam int DIV = 10;
    localparam int FRAME = 110 * DIV;
    logic clk = 0, reset_in = 0, in_valid = 0;
    logic [7:0] in_tag = 0;
    logic [31:0] in_data = 0;
    logic txd, in_ready, busy;
    logic [15:0] frames_sent;
    int passed = 0, total = 0;
    logic wave [FRAME];
    logic [7:0] line [11];
    int w;

    sdram_report_uart #(.sysclk_frequency(1), .baud_rate(10000)) dut (
        .clk(clk), .reset_in(reset_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_data(in_data), .txd(txd), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // expected ASCII line: tag, 8 uppercase hex digits MSB first, CR, LF
    task automatic build_line(input logic [7:0] tag, input logic [31:0] data);
        line[0] = tag;
        for (int i = 0; i < 8; i++) begin
            int v = (data >> (28 - 4 * i)) & 15;
            line[i + 1] = v < 10 ? 8'(48 + v) : 8'(65 + v - 10);
        end
        line[9] = 8'd13;
        line[10] = 8'd10;
    endtask

    // txd level expected during clock n after the accept edge
    function automatic logic exp_bit(input int n);
        int b = (n / DIV) % 10;
        logic [7:0] c = line[n / (10 * DIV)];
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : c[b - 1];
    endfunction

    task automatic send(input logic [7:0] tag, input logic [31:0] data, input bit hold_valid, output int waited);
        logic [15:0] f0;
        logic [7:0] got;
        int ww = 0, bad = 0;
        build_line(tag, data);
        @(negedge clk);
        in_tag = tag;
        in_data = data;
        in_valid = 1;
        while (!in_ready && ww < 2 * FRAME) begin
            @(negedge clk);
            ww++;
        end
        check("accept_timeout", ww < 2 * FRAME, 1);
        waited = ww;
        f0 = frames_sent;
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 0;
        check("start_on_accept", txd, 0);
        check("ready_low_after_accept", in_ready, 0);
        for (int n = 0; n < FRAME; n++) begin
            wave[n] = txd;
            if (n == FRAME - 1) begin
                check("busy_before_end", busy, 1);
                check("ready_before_end", in_ready, 0);
                check("frames_before_end", frames_sent, f0);
            end
            if (hold_valid) begin
                in_data = $urandom;
                in_tag = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        check("ready_at_end", in_ready, 1);
        check("busy_at_end", busy, 0);
        check("frames_at_end", frames_sent, 32'(16'(f0 + 16'd1)));
        check("idle_high_at_end", txd, 1);
        for (int n = 0; n < FRAME; n++) if (wave[n] !== exp_bit(n)) bad++;
        check("wave_exact", bad, 0);
        for (int c = 0; c < 11; c++) begin
            for (int b = 0; b < 8; b++) got[b] = wave[c * 10 * DIV + (b + 1) * DIV + DIV / 2];
            check("char", got, line[c]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        reset_in = 1;
        begin
            int lows = 0, busys = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (txd !== 1'b1) lows++;
                if (busy !== 1'b0) busys++;
            end
            check("idle_txd_low_count", lows, 0);
            check("idle_busy_count", busys, 0);
        end
        send(8'h45, 32'hDEADBEEF, 0, w);
        check("frames_after_first", frames_sent, 1);
        send(8'h50, 32'h0000000A, 0, w);
        send(8'($urandom_range(33, 126)), $urandom, 1, w);
        send(8'($urandom_range(33, 126)), $urandom, 1, w);
        check("b2b_wait", w, 0);
        send(8'($urandom_range(33, 126)), $urandom, 0, w);
        check("b2b_wait_2", w, 0);
        repeat (3) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(8'($urandom_range(33, 126)), $urandom, 0, w);
        end
        @(negedge clk);
        in_tag = 8'h45;
        in_data = 32'hDEADBEEF;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (415) @(posedge clk);
        #1;
        check("pre_abort_txd", txd, 0);
        check("pre_abort_busy", busy, 1);
        reset_in = 0;
        #1;
        check("abort_txd", txd, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        check("abort_frames", frames_sent, 0);
        reset_in = 1;
        repeat (20) @(negedge clk);
        check("post_abort_txd", txd, 1);
        check("post_abort_busy", busy, 0);
        send(8'h45, 32'h12345678, 0, w);
        check("post_abort_frames", frames_sent, 1);
        @(negedge clk);
        force dut.frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut.frames_sent;
        @(negedge clk);
        check("preload_frames", frames_sent, 16'hFFFF);
        send(8'($urandom_range(33, 126)), $urandom, 0, w);
        check("wrap_frames", frames_sent, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
